// File: rtl/seq_game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : seq_game_pkg                                                    |
// | Desc   : State encoding, LFSR constants and symbol helper functions      |
// |          shared by the memory-sequence game core.                        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package seq_game_pkg;

  // Controller states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADD      = 3'd1;
  localparam logic [2:0] S_PLAY_ON  = 3'd2;
  localparam logic [2:0] S_PLAY_OFF = 3'd3;
  localparam logic [2:0] S_WAIT_IN  = 3'd4;
  localparam logic [2:0] S_WIN      = 3'd5;
  localparam logic [2:0] S_LOSE     = 3'd6;

  // Fibonacci taps at bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  // Reset value, also substituted for an all-zero seed (the lock-up state)
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  // One LFSR step: shift left, feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

  // Bit k of the one-hot decode of a symbol
  function automatic logic sym_hit(input logic [4:0] sym, input int unsigned k);
    return {27'd0, sym} == k;
  endfunction

  // True when exactly one bit of v is set
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_game_engine_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : lfsr16                                                          |
// | Desc   : 16-bit Fibonacci LFSR with seed load and step enable.           |
// |          A zero seed is replaced by 16'h0001.                            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module lfsr16
  import seq_game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // Load has priority over stepping; zero seed would lock the register up
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_RESET;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_RESET : seed;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : seq_game_engine                                                 |
// | Desc   : Memory-sequence game core. Appends one LFSR symbol per round,   |
// |          replays the stored sequence on leds, then checks key presses    |
// |          symbol by symbol with a per-press timeout.                      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module seq_game_engine
  import seq_game_pkg::*;
#(
  parameter  int N_KEYS        = 4,
  parameter  int MAX_ROUNDS    = 16,
  parameter  int TIMEOUT_TICKS = 10,
  localparam int SYM_W         = $clog2(N_KEYS),
  localparam int RND_W         = $clog2(MAX_ROUNDS + 1)
)(
  input  logic              clock_50,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic              tick_play,
  input  logic              tick_sec,
  input  logic [N_KEYS-1:0] btn,
  output logic [N_KEYS-1:0] leds,
  output logic [RND_W-1:0]  round,
  output logic              user_turn,
  output logic              match,
  output logic              win,
  output logic              lose,
  output logic              end_time
);

  localparam int IDX_W = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int TMR_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [RND_W-1:0] RND_FINAL = RND_W'(MAX_ROUNDS);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [TMR_W-1:0]  timer;
  logic [SYM_W-1:0]  seq_mem [MAX_ROUNDS];

  logic [15:0]       lfsr_state;
  logic [SYM_W-1:0]  new_sym;
  logic              lfsr_hi_unused;
  logic              start_ok;
  logic [SYM_W-1:0]  rd_sym;
  logic [N_KEYS-1:0] exp_oh;
  logic              idx_last;
  logic              press_ok;

  // Start is honoured only from a resting state
  assign start_ok = start && ((state == S_IDLE) || (state == S_WIN) || (state == S_LOSE));

  lfsr16 u_lfsr (
    .clk    (clock_50),
    .reset  (reset),
    .load   (start_ok),
    .enable (state == S_ADD),
    .seed   (seed),
    .state  (lfsr_state)
  );

  // The high LFSR bits only feed the shift chain, never the symbol
  assign new_sym        = lfsr_state[SYM_W-1:0];
  assign lfsr_hi_unused = ^lfsr_state[15:SYM_W];

  // Symbol under the cursor, decoded to one-hot for playback and compare
  assign rd_sym = seq_mem[idx];

  for (genvar k = 0; k < N_KEYS; k++) begin : g_onehot
    assign exp_oh[k] = sym_hit(5'(rd_sym), k);
  end

  assign idx_last = (RND_W'(idx) == (round - RND_W'(1)));
  assign press_ok = is_one_hot(32'(btn)) && (btn == exp_oh);

  // Sequence store: written only while appending; deliberately not reset
  always_ff @(posedge clock_50) begin
    if (state == S_ADD) begin
      seq_mem[round[IDX_W-1:0]] <= new_sym;
    end
  end

  // Controller and round/cursor/timer datapath
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state    <= S_IDLE;
      round    <= '0;
      idx      <= '0;
      timer    <= '0;
      match    <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      end_time <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            round    <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
            end_time <= 1'b0;
            state    <= S_ADD;
          end
        end
        S_ADD: begin
          round <= round + RND_W'(1);
          idx   <= '0;
          state <= S_PLAY_ON;
        end
        S_PLAY_ON: begin
          if (tick_play) begin
            state <= S_PLAY_OFF;
          end
        end
        S_PLAY_OFF: begin
          if (tick_play) begin
            if (idx_last) begin
              idx   <= '0;
              timer <= '0;
              state <= S_WAIT_IN;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_PLAY_ON;
            end
          end
        end
        S_WAIT_IN: begin
          // A press wins over a simultaneous timeout tick
          if (btn != '0) begin
            if (press_ok) begin
              if (idx_last) begin
                match <= 1'b1;
                if (round == RND_FINAL) begin
                  win   <= 1'b1;
                  state <= S_WIN;
                end else begin
                  state <= S_ADD;
                end
              end else begin
                idx   <= idx + IDX_W'(1);
                timer <= '0;
              end
            end else begin
              lose     <= 1'b1;
              end_time <= 1'b0;
              state    <= S_LOSE;
            end
          end else if (tick_sec) begin
            if (timer == TMR_LAST) begin
              lose     <= 1'b1;
              end_time <= 1'b1;
              state    <= S_LOSE;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: playback symbol, key echo while waiting, otherwise dark
  always_comb begin
    leds      = '0;
    user_turn = 1'b0;
    case (state)
      S_PLAY_ON: leds = exp_oh;
      S_WAIT_IN: begin
        leds      = btn;
        user_turn = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_seq_game_engine                                              |
// | Desc   : Directed bench for seq_game_engine: playback, entry, loss,      |
// |          timeout, win (MAX_ROUNDS=2 instance) and mid-game reset.        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_seq_game_engine;

  logic        clock_50  = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic [15:0] seed      = 16'h0000;
  logic        tick_play = 1'b0;
  logic        tick_sec  = 1'b0;
  logic [3:0]  btn       = 4'b0000;

  logic [3:0] leds,  leds2;
  logic [4:0] round;
  logic [1:0] round2;
  logic user_turn, match, win, lose, end_time;
  logic user_turn2, match2, win2, lose2, end_time2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_oh [16];

  always #5 clock_50 = ~clock_50;

  seq_game_engine #(.N_KEYS(4), .MAX_ROUNDS(16), .TIMEOUT_TICKS(10)) dut (
    .clock_50(clock_50), .reset(reset), .start(start), .seed(seed),
    .tick_play(tick_play), .tick_sec(tick_sec), .btn(btn),
    .leds(leds), .round(round), .user_turn(user_turn), .match(match),
    .win(win), .lose(lose), .end_time(end_time)
  );

  seq_game_engine #(.N_KEYS(4), .MAX_ROUNDS(2), .TIMEOUT_TICKS(10)) dut2 (
    .clock_50(clock_50), .reset(reset), .start(start), .seed(seed),
    .tick_play(tick_play), .tick_sec(tick_sec), .btn(btn),
    .leds(leds2), .round(round2), .user_turn(user_turn2), .match(match2),
    .win(win2), .lose(lose2), .end_time(end_time2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock_50);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [15:0] s);
    seed  = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic tick_p();
    tick_play = 1'b1;
    cyc();
    tick_play = 1'b0;
  endtask

  task automatic tick_s(input int n);
    repeat (n) begin
      tick_sec = 1'b1;
      cyc();
      tick_sec = 1'b0;
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    cyc();
    btn = 4'b0000;
  endtask

  // Expects PLAY_ON of a round with n symbols; leaves the DUT in WAIT_IN
  task automatic play_round(input int n);
    for (int i = 0; i < n; i++) begin
      check_val("play_on", 32'(leds), 32'(exp_oh[i]));
      tick_p();
      check_val("play_off", 32'(leds), 0);
      tick_p();
    end
    check_val("user_turn", 32'(user_turn), 1);
  endtask

  // Enters the full correct sequence of a round with n symbols
  task automatic enter_round(input int n);
    for (int i = 0; i < n; i++) begin
      press(exp_oh[i]);
      check_val("match", 32'(match), (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic set_seq(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    for (int i = 0; i < 16; i++) exp_oh[i] = 4'b0000;
    exp_oh[0] = a;
    exp_oh[1] = b;
    exp_oh[2] = c;
    exp_oh[3] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(2);
    check_val("rst_leds", 32'(leds), 0);
    check_val("rst_round", 32'(round), 0);
    check_val("rst_turn", 32'(user_turn), 0);
    check_val("rst_match", 32'(match), 0);
    check_val("rst_win", 32'(win), 0);
    check_val("rst_lose", 32'(lose), 0);
    check_val("rst_endt", 32'(end_time), 0);
    check_val("rst_round2", 32'(round2), 0);
    reset = 1'b0;
    cyc();

    // Seed 1: symbols 1,2,0,0; rounds 1..3 entered correctly
    set_seq(4'b0010, 4'b0100, 4'b0001, 4'b0001);
    pulse_start(16'h0001);
    cyc();
    check_val("round1", 32'(round), 1);
    play_round(1);
    enter_round(1);
    cyc();
    check_val("round2", 32'(round), 2);
    play_round(2);
    enter_round(2);
    cyc();
    play_round(3);
    btn = exp_oh[0];
    #1;
    check_val("btn_echo", 32'(leds), 32'(4'b0010));
    cyc();
    btn = 4'b0000;
    check_val("match_mid", 32'(match), 0);
    press(exp_oh[1]);
    press(exp_oh[2]);
    check_val("match_r3", 32'(match), 1);
    cyc();
    check_val("round4", 32'(round), 4);
    check_val("match_clr", 32'(match), 0);
    // start is ignored during playback
    pulse_start(16'h0003);
    check_val("start_ign_rnd", 32'(round), 4);
    check_val("start_ign_led", 32'(leds), 32'(4'b0010));

    // Wrong second press in round 2
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pulse_start(16'h0001);
    cyc();
    play_round(1);
    enter_round(1);
    cyc();
    play_round(2);
    press(4'b0010);
    check_val("wrong_pre", 32'(match), 0);
    press(4'b1000);
    check_val("wrong_lose", 32'(lose), 1);
    check_val("wrong_endt", 32'(end_time), 0);
    check_val("wrong_turn", 32'(user_turn), 0);
    check_val("wrong_match", 32'(match), 0);
    press(4'b0010);
    tick_s(12);
    check_val("lose_held", 32'(lose), 1);
    check_val("lose_endt", 32'(end_time), 0);

    // Timeout after 10 silent ticks
    pulse_start(16'h0001);
    check_val("restart_lose", 32'(lose), 0);
    cyc();
    play_round(1);
    tick_s(9);
    check_val("to9_lose", 32'(lose), 0);
    check_val("to9_turn", 32'(user_turn), 1);
    tick_s(1);
    check_val("to10_lose", 32'(lose), 1);
    check_val("to10_endt", 32'(end_time), 1);
    check_val("to10_turn", 32'(user_turn), 0);

    // Seed 3: symbols 3,2,0,0; press on the 10th tick wins over the tick
    set_seq(4'b1000, 4'b0100, 4'b0001, 4'b0001);
    pulse_start(16'h0003);
    check_val("restart_endt", 32'(end_time), 0);
    cyc();
    play_round(1);
    tick_s(9);
    btn      = 4'b1000;
    tick_sec = 1'b1;
    cyc();
    btn      = 4'b0000;
    tick_sec = 1'b0;
    check_val("race_match", 32'(match), 1);
    check_val("race_lose", 32'(lose), 0);
    cyc();
    check_val("race_round", 32'(round), 2);
    play_round(2);
    tick_s(5);
    press(4'b1000);
    check_val("tr_match", 32'(match), 0);
    check_val("tr_turn", 32'(user_turn), 1);
    tick_s(9);
    check_val("tr9_lose", 32'(lose), 0);
    tick_s(1);
    check_val("tr10_lose", 32'(lose), 1);
    check_val("tr10_endt", 32'(end_time), 1);

    // Win on the MAX_ROUNDS=2 instance
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_seq(4'b0010, 4'b0100, 4'b0001, 4'b0001);
    pulse_start(16'h0001);
    cyc();
    play_round(1);
    enter_round(1);
    check_val("win2_early", 32'(win2), 0);
    cyc();
    play_round(2);
    enter_round(2);
    check_val("win2_set", 32'(win2), 1);
    check_val("match2", 32'(match2), 1);
    check_val("win_big", 32'(win), 0);
    cyc(3);
    check_val("win2_held", 32'(win2), 1);
    check_val("win2_round", 32'(round2), 2);
    pulse_start(16'h0001);
    check_val("win2_clr", 32'(win2), 0);
    cyc();
    check_val("win2_rnd1", 32'(round2), 1);
    check_val("big_rnd3", 32'(round), 3);

    // Reset during PLAY_ON, then a two-bit press loses
    reset = 1'b1;
    cyc();
    check_val("mr_leds", 32'(leds), 0);
    check_val("mr_round", 32'(round), 0);
    check_val("mr_turn", 32'(user_turn), 0);
    check_val("mr_leds2", 32'(leds2), 0);
    check_val("mr_round2", 32'(round2), 0);
    reset = 1'b0;
    pulse_start(16'h0000);
    cyc();
    play_round(1);
    press(4'b0011);
    check_val("multi_lose", 32'(lose), 1);
    check_val("multi_endt", 32'(end_time), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
